// File: rtl/posit_pkg.sv
// Shared constants and types for the posit multiplier front-end.
package posit_pkg;

  localparam int unsigned POSIT_W = 32;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned BYTE_W  = 8;

  // Not-a-Real encoding for a 32-bit posit
  localparam logic [POSIT_W-1:0] NAR = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    OUT_HI,
    OUT_LO
  } seq_state_t;

endpackage

// File: rtl/posit_mul_sequencer.sv
// Byte-stream front-end for the 32-bit posit multiplier: gathers A then B (MSB byte
// first), waits for the multiplier to settle, and returns the product as two halves.
module posit_mul_sequencer
  import posit_pkg::*;
#(
  parameter int unsigned MUL_WAIT     = 1,
  parameter bit          NAR_ON_ERROR = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BYTE_W-1:0]  in_byte,
  output logic [POSIT_W-1:0] mul_a,
  output logic [POSIT_W-1:0] mul_b,
  input  logic [POSIT_W-1:0] mul_product,
  input  logic               mul_error,
  input  logic               mul_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [HALF_W-1:0]  out_half,
  output logic               out_last,
  output logic               out_error,
  output logic               out_zero,
  output logic               busy,
  output logic [15:0]        op_count
);

  localparam int unsigned WAIT_W = (MUL_WAIT > 1) ? $clog2(MUL_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MUL_WAIT - 1);

  seq_state_t         state_q, state_d;
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [POSIT_W-1:0] mul_a_q, mul_a_d;
  logic [POSIT_W-1:0] mul_b_q, mul_b_d;
  logic [HALF_W-1:0]  res_lo_q, res_lo_d;
  logic [HALF_W-1:0]  out_half_q, out_half_d;
  logic               out_last_q, out_last_d;
  logic               out_error_q, out_error_d;
  logic               out_zero_q, out_zero_d;
  logic [15:0]        op_count_q, op_count_d;

  logic               in_fire;
  logic               out_fire;
  logic [POSIT_W-1:0] result;

  assign in_ready  = ~reset & ((state_q == IDLE) | (state_q == LOAD));
  assign out_valid = (state_q == OUT_HI) | (state_q == OUT_LO);
  assign busy      = (state_q != IDLE);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_half  = out_half_q;
  assign out_last  = out_last_q;
  assign out_error = out_error_q;
  assign out_zero  = out_zero_q;
  assign op_count  = op_count_q;

  // Next-state: operand assembly, settle wait, result capture and half sequencing
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    wait_d      = wait_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_lo_d    = res_lo_q;
    out_half_d  = out_half_q;
    out_last_d  = out_last_q;
    out_error_d = out_error_q;
    out_zero_d  = out_zero_q;
    op_count_d  = op_count_q;
    result      = (mul_error && NAR_ON_ERROR) ? NAR : mul_product;

    if (flush) begin
      // Abort drops any in-flight handshake; operands are intentionally kept
      state_d    = IDLE;
      byte_cnt_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            mul_a_d[POSIT_W-1 -: BYTE_W] = in_byte;
            byte_cnt_d = 3'd1;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          if (in_fire) begin
            if (!byte_cnt_q[2]) begin
              mul_a_d[POSIT_W-1 - BYTE_W*int'(byte_cnt_q[1:0]) -: BYTE_W] = in_byte;
            end else begin
              mul_b_d[POSIT_W-1 - BYTE_W*int'(byte_cnt_q[1:0]) -: BYTE_W] = in_byte;
            end
            // Wraps 7 -> 0, leaving the counter ready for the next operation
            byte_cnt_d = 3'(byte_cnt_q + 3'd1);
            if (byte_cnt_q == 3'd7) begin
              wait_d  = WAIT_INIT;
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_q == '0) begin
            out_half_d  = result[POSIT_W-1:HALF_W];
            res_lo_d    = result[HALF_W-1:0];
            out_last_d  = 1'b0;
            out_error_d = mul_error;
            out_zero_d  = mul_zero;
            state_d     = OUT_HI;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end
        OUT_HI: begin
          if (out_fire) begin
            out_half_d = res_lo_q;
            out_last_d = 1'b1;
            state_d    = OUT_LO;
          end
        end
        OUT_LO: begin
          if (out_fire) begin
            op_count_d = op_count_q + 16'd1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_cnt_q  <= 3'd0;
      wait_q      <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_lo_q    <= '0;
      out_half_q  <= '0;
      out_last_q  <= 1'b0;
      out_error_q <= 1'b0;
      out_zero_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      wait_q      <= wait_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_lo_q    <= res_lo_d;
      out_half_q  <= out_half_d;
      out_last_q  <= out_last_d;
      out_error_q <= out_error_d;
      out_zero_q  <= out_zero_d;
      op_count_q  <= op_count_d;
    end
  end

endmodule

// File: tb/tb_posit_mul_sequencer.sv
// Harness for posit_mul_sequencer with a behavioural stand-in for posit_multiplier.
module tb_posit_mul_sequencer;
  import posit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [7:0]  in_byte;
  logic        in_ready, out_valid, out_last, out_error, out_zero, busy;
  logic [31:0] mul_a, mul_b, mul_product;
  logic        mul_error, mul_zero;
  logic [15:0] out_half, op_count;

  typedef struct packed {
    logic [15:0] half;
    logic        last;
    logic        err;
    logic        zero;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_ops = 16'd0;

  always #5 clk = ~clk;

  posit_mul_sequencer #(
    .MUL_WAIT    (1),
    .NAR_ON_ERROR(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_product(mul_product),
    .mul_error  (mul_error),
    .mul_zero   (mul_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_half   (out_half),
    .out_last   (out_last),
    .out_error  (out_error),
    .out_zero   (out_zero),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Stand-in multiplier: exact for zero and 1.0 operands, maxpos flags regime overflow.
  // Returns {error, zero, product}.
  function automatic logic [33:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'd0 || b == 32'd0)                   return {1'b0, 1'b1, 32'd0};
    if (a == 32'h7FFF_FFFF || b == 32'h7FFF_FFFF)   return {1'b1, 1'b0, a ^ b};
    if (a == 32'h4000_0000)                         return {1'b0, 1'b0, b};
    if (b == 32'h4000_0000)                         return {1'b0, 1'b0, a};
    return {1'b0, 1'b0, a ^ b};
  endfunction

  always_comb {mul_error, mul_zero, mul_product} = mul_model(mul_a, mul_b);

  task automatic push_expected(input logic [31:0] a, input logic [31:0] b);
    logic [33:0] m;
    logic [31:0] res;
    m   = mul_model(a, b);
    res = m[33] ? NAR : m[31:0];
    sb.push_back('{half: res[31:16], last: 1'b0, err: m[33], zero: m[32]});
    sb.push_back('{half: res[15:0],  last: 1'b1, err: m[33], zero: m[32]});
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input int gap);
    logic [63:0] ab;
    ab = {a, b};
    push_expected(a, b);
    for (int i = 0; i < 8; i++) send_byte(ab[63-8*i -: 8], gap);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_state: in_ready=%0b busy=%0b required 0/1", in_ready, busy);
    end
  endtask

  task automatic recv_half(input int stall);
    int   n;
    exp_t e;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1 within 50 cycles", out_valid);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output: half=%h with empty scoreboard, required none", out_half);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL in_ready_out: in_ready=%0b required 0", in_ready);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_half !== e.half) begin
        errors++;
        $display("FAIL stall_hold: valid=%0b half=%h required 1/%h", out_valid, out_half, e.half);
      end
    end
    checks++;
    if (out_half !== e.half || out_last !== e.last || out_error !== e.err ||
        out_zero !== e.zero) begin
      errors++;
      $display("FAIL half_data: half=%h last=%0b err=%0b zero=%0b required %h/%0b/%0b/%0b",
               out_half, out_last, out_error, out_zero, e.half, e.last, e.err, e.zero);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic recv_op(input int stall_hi);
    recv_half(stall_hi);
    recv_half(0);
    exp_ops = exp_ops + 16'd1;
    checks++;
    if (op_count !== exp_ops || busy !== 1'b0) begin
      errors++;
      $display("FAIL op_done: op_count=%h busy=%0b required %h/0", op_count, busy, exp_ops);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_byte = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0 ||
        mul_a !== 32'd0 || mul_b !== 32'd0 || out_half !== 16'd0 || out_last !== 1'b0 ||
        out_error !== 1'b0 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b busy=%0b cnt=%h a=%h b=%h half=%h l/e/z=%0b%0b%0b required all 0",
               in_ready, out_valid, busy, op_count, mul_a, mul_b, out_half,
               out_last, out_error, out_zero);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_one_times_one();
    send_op(32'h4000_0000, 32'h4000_0000, 0);
    recv_op(0);
  endtask

  task automatic test_byte_order();
    send_op(32'h4A3B_2C1D, 32'h4000_0000, 0);
    recv_op(0);
    send_op(32'h4000_0000, 32'h5E6F_7081, 0);
    recv_op(0);
  endtask

  task automatic test_zero();
    send_op(32'h4000_0000, 32'h0000_0000, 0);
    recv_op(0);
  endtask

  task automatic test_error();
    send_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    recv_op(0);
  endtask

  task automatic test_backpressure();
    send_op(32'h4000_0000, 32'h4000_0000, 1);
    recv_op(5);
  endtask

  task automatic test_flush();
    logic [63:0] ab;
    ab = {32'h4A3B_2C1D, 32'h1122_3344};
    for (int i = 0; i < 5; i++) send_byte(ab[63-8*i -: 8], 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: busy=%0b out_valid=%0b in_ready=%0b required 0/0/1",
               busy, out_valid, in_ready);
    end
    checks++;
    if (mul_a !== 32'h4A3B_2C1D || mul_b[31:24] !== 8'h11) begin
      errors++;
      $display("FAIL flush_keep: mul_a=%h mul_b=%h required 4a3b2c1d/11xxxxxx", mul_a, mul_b);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || op_count !== exp_ops) begin
      errors++;
      $display("FAIL flush_no_output: out_valid=%0b op_count=%h required 0/%h",
               out_valid, op_count, exp_ops);
    end
    send_op(32'h4000_0000, 32'h4000_0000, 0);
    recv_op(0);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    exp_ops = 16'hFFFF;
    send_op(32'h4000_0000, 32'h4000_0000, 0);
    recv_op(0);
    checks++;
    if (op_count !== 16'h0000) begin
      errors++;
      $display("FAIL count_wrap: op_count=%h required 0000", op_count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send_op(32'h4000_0000, 32'h4000_0000, 0);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0 || mul_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%0b busy=%0b op_count=%h mul_a=%h required 0/0/0/0",
               out_valid, busy, op_count, mul_a);
    end
    reset = 1'b0;
    sb.delete();
    exp_ops = 16'd0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_one_times_one();
    test_byte_order();
    test_zero();
    test_error();
    test_backpressure();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
